stoch_to_bin: RTL and testbench
===============================

Name: stoch_to_bin

Overview:
- Decoder for stochastic bitstreams. Converts N parallel unipolar streams into binary counts by accumulating ones over a fixed window of 2^W sampled cycles.
- Sits at the output end of the stochastic datapath. It consumes streams produced by multiplier and gate cascades and hands binary results to downstream logic through a valid/ready handshake.

Parameters:
- N, 2, number of parallel stochastic input lanes (N >= 1).
- W, 8, log2 of the window length; window = 2^W sampled cycles (W >= 1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  sample enable; when low, the current cycle is not counted and the window does not advance.
- START  input  1  single-cycle request to begin a new conversion window.
- IN  input  N  stochastic bits, one per lane; lane i = IN[i].
- OUT  output  N*(W+1)  latched results; lane i occupies OUT[i*(W+1) +: W+1].
- VALID  output  1  OUT holds a completed result.
- READY  input  1  downstream accepts the result.
- BUSY  output  1  a window is in progress.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; OUT=0, VALID=0, BUSY=0; all lane counters and the window counter are cleared.
- Counter widths:
  - Lane counters are W+1 bits; range 0..2^W, no saturation needed.
  - Window counter is W bits; the last sample is detected at count 2^W-1, so there is no wrap.
- IDLE:
  - On START=1, clear the lane and window counters, go to COUNT, and set BUSY=1.
  - IN is ignored while in IDLE.
- COUNT:
  - On each edge with EN=1: every lane counter adds IN[i], and the window counter increments.
  - On edges with EN=0: nothing changes.
- Window completion: when the window counter is 2^W-1 and EN=1, that edge:
  - writes the final counts (including the current IN) to OUT;
  - sets VALID=1 and BUSY=0;
  - moves to HOLD.
- Latency: with START sampled at edge k and EN held high, samples are taken at edges k+1..k+2^W. VALID is high after edge k+2^W.
- START during COUNT: the window restarts. Counters clear on that edge, the state stays COUNT, and the IN of that cycle is discarded.
- HOLD:
  - OUT is stable while VALID=1.
  - On VALID&READY, clear VALID and go to IDLE.
  - START alone in HOLD is ignored and not queued.
  - If READY=1 and START=1 on the same edge, the handshake completes and the block goes directly to COUNT with cleared counters (BUSY=1, VALID=0).
- OUT keeps its last value after the handshake until the next window completes.
- RST_N asserted mid-window or in HOLD aborts immediately to the reset state; no partial result is reported.
- EN does not gate START or the handshake.

Optional Feature:
- Macro: STB_BIPOLAR_EN.
- When defined: each lane's OUT field is a two's-complement bipolar value, 2*count - 2^W. The range is -2^W..+2^W, so the field width becomes W+2 and OUT is N*(W+2) bits. Lane i occupies OUT[i*(W+2) +: W+2].
- When undefined: unipolar count, field width W+1 as above.
- Counting, timing and the handshake are identical in both modes.

Test Plan:
- N=2, W=4; START, EN=1, IN=2'b11 for 16 cycles -> VALID after the 16th sample edge; lane0=16, lane1=16; BUSY falls as VALID rises.
- Lane0 alternating 1/0, lane1 tied 0, 16 cycles, READY=1 -> lane0=8, lane1=0; VALID high for exactly one cycle, then IDLE.
- IN=2'b01, with EN low for 5 cycles inserted mid-window -> VALID only after 16 enabled cycles (21 after START); lane0=16, lane1=0.
- START re-pulsed after 10 samples of IN=2'b11, then IN=2'b10 for 16 cycles -> lane0=0, lane1=16; no VALID before the restarted window ends.
- READY=0 for 7 cycles after VALID, with START pulsed during HOLD -> OUT stable and VALID held; START ignored. Then READY=1 together with START -> VALID drops, BUSY=1, and a new window completes 16 samples later.
- RST_N pulsed low after 9 samples -> OUT=0, VALID=0, BUSY=0 immediately. With STB_BIPOLAR_EN defined, a full window of 12 ones out of 16 gives 8, and 4 ones out of 16 gives -8.

Source files
------------

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary decoder: counts ones per lane over a 2^W-sample window, valid/ready out.
// Define STB_BIPOLAR_EN to report each lane as the bipolar value 2*count - 2^W (W+2 bits).
module stoch_to_bin #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 8,
`ifdef STB_BIPOLAR_EN
    localparam int unsigned FW = W + 2
`else
    localparam int unsigned FW = W + 1
`endif
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            START,
    input  logic [N-1:0]    IN,
    output logic [N*FW-1:0] OUT,
    output logic            VALID,
    input  logic            READY,
    output logic            BUSY
);

    localparam int unsigned CW = W + 1;

    typedef enum logic [1:0] {StIdle, StCount, StHold} state_e;

    state_e         state_q;
    logic [W-1:0]   win_q;
    logic [CW-1:0]  cnt_q   [N];
    logic [CW-1:0]  cnt_inc [N];
    logic [N*FW-1:0] final_out;

`ifdef STB_BIPOLAR_EN
    localparam logic [FW-1:0] Offset = {2'b01, {W{1'b0}}};
`endif

    // Lane counts including the current sample, and their output encoding.
    always_comb begin
        final_out = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_inc[i] = cnt_q[i] + CW'(IN[i]);
`ifdef STB_BIPOLAR_EN
            final_out[i*FW +: FW] = {cnt_inc[i], 1'b0} - Offset;
`else
            final_out[i*FW +: FW] = cnt_inc[i];
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            OUT     <= '0;
            VALID   <= 1'b0;
            BUSY    <= 1'b0;
            win_q   <= '0;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        win_q <= '0;
                        for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
                        BUSY    <= 1'b1;
                        state_q <= StCount;
                    end
                end
                StCount: begin
                    if (START) begin
                        // Restart: the sample of this cycle is discarded.
                        win_q <= '0;
                        for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
                    end else if (EN) begin
                        if (win_q == '1) begin
                            OUT     <= final_out;
                            VALID   <= 1'b1;
                            BUSY    <= 1'b0;
                            state_q <= StHold;
                        end else begin
                            win_q <= win_q + 1'b1;
                            for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_inc[i];
                        end
                    end
                end
                StHold: begin
                    if (READY) begin
                        VALID <= 1'b0;
                        if (START) begin
                            win_q <= '0;
                            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
                            BUSY    <= 1'b1;
                            state_q <= StCount;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_to_bin.sv
// Bench for stoch_to_bin: directed scenarios plus random traffic against a sample-queue model.
module tb_stoch_to_bin;

    localparam int N = 2;
    localparam int W = 4;
`ifdef STB_BIPOLAR_EN
    localparam int FW = W + 2;
`else
    localparam int FW = W + 1;
`endif
    localparam int WIN = 1 << W;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            EN = 1'b0;
    logic            START = 1'b0;
    logic            READY = 1'b0;
    logic [N-1:0]    IN = '0;
    logic [N*FW-1:0] OUT;
    logic            VALID;
    logic            BUSY;

    stoch_to_bin #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .START (START),
        .IN    (IN),
        .OUT   (OUT),
        .VALID (VALID),
        .READY (READY),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the window is the list of samples taken since the last (re)start.
    bit              m_busy;
    bit              m_valid;
    logic [N*FW-1:0] m_out;
    int              samples[$];

    function automatic logic [FW-1:0] lane_val(int count);
`ifdef STB_BIPOLAR_EN
        int v = 2 * count - WIN;
        return FW'(v);
`else
        return FW'(count);
`endif
    endfunction

    function automatic logic [N*FW-1:0] pack_window();
        logic [N*FW-1:0] r = '0;
        for (int l = 0; l < N; l++) begin
            int c = 0;
            foreach (samples[j]) c += (samples[j] >> l) & 1;
            r[l*FW +: FW] = lane_val(c);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_out   = '0;
        samples.delete();
    endtask

    task automatic model_edge();
        if (m_valid) begin
            if (READY) begin
                m_valid = 1'b0;
                if (START) begin
                    m_busy = 1'b1;
                    samples.delete();
                end
            end
        end else if (m_busy) begin
            if (START) begin
                samples.delete();
            end else if (EN) begin
                samples.push_back(int'(IN));
                if (samples.size() == WIN) begin
                    m_out   = pack_window();
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
            end
        end else if (START) begin
            m_busy = 1'b1;
            samples.delete();
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_out"}, 32'(OUT), 32'(m_out));
        check({tag, "_valid"}, 32'(VALID), 32'(m_valid));
        check({tag, "_busy"}, 32'(BUSY), 32'(m_busy));
    endtask

    // One clock cycle: drive inputs, model the edge, check at the following falling edge.
    task automatic step(input bit en, input bit st, input logic [N-1:0] in, input bit rdy,
                        input string tag);
        EN    = en;
        START = st;
        IN    = in;
        READY = rdy;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_state(tag);
    endtask

    task automatic pulse_reset(input string tag);
        START = 1'b0;
        RST_N = 1'b0;
        #1;
        model_clear();
        check_state(tag);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        model_clear();
        #2;
        check_state("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        step(1, 0, 2'b11, 0, "idle_ignores_in");

        // Full window of ones on both lanes.
        step(1, 1, 2'b11, 0, "s1_start");
        for (int i = 0; i < WIN; i++) step(1, 0, 2'b11, 0, "s1_count");
        check("s1_lane0", 32'(OUT[0 +: FW]), 32'(lane_val(16)));
        check("s1_lane1", 32'(OUT[FW +: FW]), 32'(lane_val(16)));
        step(1, 0, 2'b00, 1, "s1_ack");

        // Alternating lane0, READY held high.
        step(1, 1, 2'b00, 1, "s2_start");
        for (int i = 0; i < WIN; i++) step(1, 0, {1'b0, (i % 2 == 0)}, 1, "s2_count");
        check("s2_lane0", 32'(OUT[0 +: FW]), 32'(lane_val(8)));
        step(1, 0, 2'b00, 1, "s2_ack");
        step(1, 0, 2'b00, 1, "s2_idle");

        // EN gaps stretch the window.
        step(1, 1, 2'b01, 0, "s3_start");
        for (int i = 0; i < WIN + 5; i++) step(!(i >= 8 && i < 13), 0, 2'b01, 0, "s3_count");
        check("s3_valid", 32'(VALID), 32'd1);
        step(1, 0, 2'b00, 1, "s3_ack");

        // Restart mid-window.
        step(1, 1, 2'b11, 0, "s4_start");
        for (int i = 0; i < 10; i++) step(1, 0, 2'b11, 0, "s4_pre");
        step(1, 1, 2'b11, 0, "s4_restart");
        for (int i = 0; i < WIN; i++) step(1, 0, 2'b10, 0, "s4_count");
        check("s4_lane1", 32'(OUT[FW +: FW]), 32'(lane_val(16)));

        // HOLD with READY low and a stray START, then READY+START.
        for (int i = 0; i < 7; i++) step(1, (i == 3), 2'b11, 0, "s5_hold");
        step(1, 1, 2'b11, 1, "s5_ack_start");
        for (int i = 0; i < WIN; i++) step(1, 0, 2'b01, 0, "s5_count");
        step(1, 0, 2'b00, 1, "s5_ack");

        // Asynchronous reset mid-window.
        step(1, 1, 2'b11, 0, "s6_start");
        for (int i = 0; i < 9; i++) step(1, 0, 2'b11, 0, "s6_count");
        pulse_reset("s6_reset");
        step(1, 0, 2'b00, 0, "s6_after");

        // 12 ones on lane0, 4 on lane1.
        step(1, 1, 2'b00, 0, "s7_start");
        for (int i = 0; i < WIN; i++) step(1, 0, {(i < 4), (i < 12)}, 0, "s7_count");
        check("s7_lane0", 32'(OUT[0 +: FW]), 32'(lane_val(12)));
        check("s7_lane1", 32'(OUT[FW +: FW]), 32'(lane_val(4)));
        step(1, 0, 2'b00, 1, "s7_ack");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) pulse_reset("rnd_reset");
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 N'($urandom), $urandom_range(0, 1) == 1, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
